// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, variable-latency memory between the
// instruction-fetch port and the data port. Data wins conflicts, but a streak
// counter forces a fetch grant after MAX_DM_STREAK back-to-back data grants
// while fetch is waiting.
module mem_arbiter #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned MAX_DM_STREAK = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_req,
    input  logic [ADDR_WIDTH-1:0]     if_addr,
    output logic [DATA_WIDTH-1:0]     if_rdata,
    output logic                      if_valid,
    input  logic                      dm_req,
    input  logic                      dm_we,
    input  logic [ADDR_WIDTH-1:0]     dm_addr,
    input  logic [DATA_WIDTH-1:0]     dm_wdata,
    input  logic [DATA_WIDTH/8-1:0]   dm_wstrb,
    output logic [DATA_WIDTH-1:0]     dm_rdata,
    output logic                      dm_valid,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    input  logic                      mem_ready,
    output logic                      busy
);

    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned STREAK_W = $clog2(MAX_DM_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_grant_dm;
    logic                  w_grant_if;
    logic                  w_complete;

    logic                  r_owner_dm;
    logic [STREAK_W-1:0]   r_streak;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [STRB_W-1:0]     r_mem_wstrb;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_dm_rdata;
    logic                  r_if_valid;
    logic                  r_dm_valid;

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign if_valid  = r_if_valid;
    assign dm_valid  = r_dm_valid;
    assign busy      = (r_state != ST_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, grant decision and memory-completion decode
    always_comb begin
        w_state_nxt = r_state;
        w_grant_dm  = 1'b0;
        w_grant_if  = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Data wins unless fetch has waited through a full streak
                w_grant_dm = dm_req && !(if_req && (r_streak == STREAK_MAX));
                w_grant_if = if_req && !w_grant_dm;
                if (w_grant_dm || w_grant_if) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Memory request registers: loaded on grant, held through BUSY
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_owner_dm  <= 1'b0;
        end else if (w_grant_dm) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= dm_we;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
            r_mem_wstrb <= dm_we ? dm_wstrb : '0;
            r_owner_dm  <= 1'b1;
        end else if (w_grant_if) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_owner_dm  <= 1'b0;
        end else if (w_complete) begin
            r_mem_req   <= 1'b0;
        end
    end

    // Response capture into the owner's rdata and one-cycle valid pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
        end else begin
            r_if_valid <= w_complete && !r_owner_dm;
            r_dm_valid <= w_complete && r_owner_dm;
            if (w_complete && r_owner_dm) begin
                r_dm_rdata <= mem_rdata;
            end
            if (w_complete && !r_owner_dm) begin
                r_if_rdata <= mem_rdata;
            end
        end
    end

    // Consecutive data grants while fetch waits; saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak <= '0;
        end else if (w_grant_dm) begin
            if (!if_req) begin
                r_streak <= '0;
            end else if (r_streak != STREAK_MAX) begin
                r_streak <= r_streak + STREAK_W'(1);
            end
        end else if (w_grant_if) begin
            r_streak <= '0;
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the CPU's instruction-fetch port and data-memory port onto one shared, single-ported memory with variable-latency `mem_ready` handshaking. It sits between `top_fetch`/`top_memory` and a unified instruction/data memory. It also produces the stall information the core needs while an access is outstanding. Data accesses win conflicts, and a streak counter guarantees that fetch is never starved.

## Interface
- `DATA_WIDTH`, 32, data bus width (multiple of 8)
- `ADDR_WIDTH`, 32, byte-address width
- `MAX_DM_STREAK`, 4, maximum consecutive data grants while fetch is waiting (≥1)

- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request, level; held until `if_valid`
- `if_addr`  in  ADDR_WIDTH  fetch address
- `if_rdata`  out  DATA_WIDTH  fetched word; holds until the next fetch response
- `if_valid`  out  1  one-cycle pulse: fetch complete
- `dm_req`  in  1  data request, level; held until `dm_valid`
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  ADDR_WIDTH  data address
- `dm_wdata`  in  DATA_WIDTH  store data
- `dm_wstrb`  in  DATA_WIDTH/8  store byte enables
- `dm_rdata`  out  DATA_WIDTH  load data; holds until the next data response
- `dm_valid`  out  1  one-cycle pulse: data access complete
- `mem_req`  out  1  memory request, held until `mem_ready`
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_wdata`  out  DATA_WIDTH  memory write data
- `mem_wstrb`  out  DATA_WIDTH/8  write strobes; all zero on reads
- `mem_rdata`  in  DATA_WIDTH  read data, valid with `mem_ready`
- `mem_ready`  in  1  access complete this cycle
- `busy`  out  1  FSM not in IDLE

## Operation
- The FSM has three states: IDLE, BUSY, RESP.
- **IDLE**
  - Samples `if_req` and `dm_req`.
  - If neither is asserted, stay in IDLE.
  - If only one is asserted, grant it.
  - If both are asserted, grant data unless `dm_streak == MAX_DM_STREAK`, in which case grant fetch.
  - On a grant, register the address, we, wdata and wstrb into the `mem_*` outputs, record the granted port in `owner`, and go to BUSY.
  - Fetch grants drive `mem_we=0` and `mem_wstrb=0`. Data loads force `mem_wstrb=0`.
- **BUSY**
  - `mem_req=1`. All `mem_*` outputs stay stable.
  - On `mem_ready=1`: capture `mem_rdata` into the owner's rdata register. This is also done for stores; the value is don't-care but must be deterministic. Go to RESP.
  - With `mem_ready=0`, wait indefinitely.
- **RESP**
  - `mem_req=0`. Pulse the owner's valid output for exactly one cycle, then go to IDLE.
- **`dm_streak` counter** (saturating at MAX_DM_STREAK)
  - On a data grant with `if_req=1`: increment.
  - On a data grant with `if_req=0`: clear.
  - On a fetch grant: clear.
- `if_rdata` is updated only by fetch responses; `dm_rdata` only by data responses.
- Requesters must deassert or change their request in the cycle their valid pulse is high. A request still high in the following IDLE cycle is a new access.
- `mem_ready` outside BUSY is ignored.

## Timing
- All outputs are registered except `busy`, which is decoded from state.
- **Reset values:** state=IDLE, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `mem_wstrb=0`, `if_valid=0`, `dm_valid=0`, `if_rdata=0`, `dm_rdata=0`, `dm_streak=0`, `owner`=fetch.
- **Latency:** request sampled in IDLE at cycle N; `mem_req` high from N+1. If `mem_ready` arrives at cycle N+1+W (W wait states), valid is high at N+2+W.
- **Minimum occupancy:** 3 cycles per access (IDLE, BUSY, RESP) with a zero-wait memory.
- **Reset mid-access:** return to IDLE next edge, drop `mem_req`, emit no valid pulse, clear the streak. Any late `mem_ready` is ignored.
- Request inputs changing during BUSY or RESP have no effect on the access in flight.

## Test plan
- **Single fetch, zero-wait:** `if_req=1`, `if_addr=0x100`, memory returns `0x00500093` in the first BUSY cycle. Required: `mem_req` is high for 1 cycle with `mem_addr=0x100` and `mem_wstrb=0`; `if_valid` pulses 2 cycles after sampling with `if_rdata=0x00500093`; `dm_valid` stays 0.
- **Conflict:** `if_req` and `dm_req` (load, addr `0x1000`) rise in the same cycle. Required: data granted first (`mem_addr=0x1000`), `dm_valid` pulses first, then the fetch is served next with `if_valid`.
- **Starvation guard:** `MAX_DM_STREAK=4`, `dm_req` held continuously and `if_req` held. Required: exactly 4 data accesses, then 1 fetch, then data resumes; the pattern repeats.
- **Store with wait states:** `dm_we=1`, `dm_addr=0x2004`, `dm_wdata=0xDEADBEEF`, `dm_wstrb=4'b0011`, `mem_ready` delayed 3 cycles. Required: `mem_*` stable for 4 BUSY cycles, `mem_wstrb=4'b0011`, `dm_valid` pulses on the cycle after `mem_ready`.
- **Reset mid-access:** `rst` asserted during BUSY, then `mem_ready` pulsed one cycle later. Required: `mem_req=0`, `busy=0`, no valid pulse, rdata registers = 0.
- **Stale ready:** `mem_ready=1` while in IDLE. Required: no state change and no valid pulse.
